// File: rtl/mul_iter_sequencer_pkg.sv
// Shared definitions for the iterative shift-add MUL sequencer: default width and FSM encodings.
package mul_iter_sequencer_pkg;

    localparam int unsigned MUL_DATA_W = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_step.sv
// One combinational shift-add multiply iteration: conditional accumulate, then shift operands.
module mul_shift_add_step
    import mul_iter_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = MUL_DATA_W
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic [DATA_W-1:0] acc_nxt_c,
    output logic [DATA_W-1:0] mcand_nxt_c,
    output logic [DATA_W-1:0] mplier_nxt_c
);

    // Only the low product half is kept, so the sum simply wraps.
    assign acc_nxt_c    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nxt_c  = mcand << 1;
    assign mplier_nxt_c = mplier >> 1;

endmodule

// File: rtl/mul_iter_sequencer.sv
// Multi-cycle shift-add MUL sequencer for EX; stalls the pipeline until the low product half is ready.
// Optional build macro: MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module mul_iter_sequencer
    import mul_iter_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = MUL_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned    CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] step_acc_c;
    logic [DATA_W-1:0] step_mcand_c;
    logic [DATA_W-1:0] step_mplier_c;
    logic              last_step_c;

    mul_shift_add_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc          (acc_q),
        .mcand        (mcand_q),
        .mplier       (mplier_q),
        .acc_nxt_c    (step_acc_c),
        .mcand_nxt_c  (step_mcand_c),
        .mplier_nxt_c (step_mplier_c)
    );

    // Final iteration: counter exhausted, or (early build) no multiplier bits left to add.
`ifdef MUL_EARLY_TERM_EN
    assign last_step_c = (cnt_q == LAST_CNT) || (step_mplier_c == '0);
`else
    assign last_step_c = (cnt_q == LAST_CNT);
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= MUL_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state, datapath update and the combinational stall.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        stall_o  = 1'b0;

        case (state_q)
            MUL_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o  = 1'b1;
                    state_d  = MUL_BUSY;
                    acc_d    = '0;
                    mcand_d  = op_a_i;
                    mplier_d = op_b_i;
                    cnt_d    = '0;
                end
            end
            MUL_BUSY: begin
                if (flush_i) begin
                    state_d = MUL_IDLE;
                end else begin
                    stall_o  = 1'b1;
                    acc_d    = step_acc_c;
                    mcand_d  = step_mcand_c;
                    mplier_d = step_mplier_c;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_step_c) begin
                        state_d  = MUL_DONE;
                        done_d   = 1'b1;
                        result_d = step_acc_c;
                    end
                end
            end
            // EX still holds the retiring MUL here, so a new start is not taken.
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter_sequencer.sv
// Directed self-checking bench for mul_iter_sequencer (latency expectations follow MUL_EARLY_TERM_EN).
module tb_mul_iter_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_pass;
    int n_total;

    mul_iter_sequencer #(.DATA_W(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Cycles from accepted start to done_o.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return (msb < 0) ? 2 : msb + 2;
`else
        return 33;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one MUL from IDLE and measure it; leaves the bench in the done_o cycle (or after timeout).
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit stall_ok, output logic [31:0] res);
        op_a_i  = a;
        op_b_i  = b;
        start_i = 1'b1;
        #1;
        stall_ok = (stall_o === 1'b1);
        lat = -1;
        res = 'x;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            if (k > 1) tick();
            if (done_o === 1'b1) begin
                lat = k;
                res = result_o;
                if (stall_o !== 1'b0) stall_ok = 0;
            end else if (stall_o !== 1'b1) begin
                stall_ok = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #3;
        n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else n_pass++;
        n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
        n_total++; if (result_o !== 32'h0) $display("FAIL reset_result: got %h want 0", result_o); else n_pass++;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; bit ok; logic [31:0] res;
        do_mul(32'd7, 32'd6, lat, ok, res);
        n_total++; if (lat !== exp_lat(32'd6)) $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(32'd6)); else n_pass++;
        n_total++; if (res !== 32'd42) $display("FAIL basic_result: got %h want %h", res, 32'd42); else n_pass++;
        n_total++; if (!ok) $display("FAIL basic_stall: stall_o shape got bad want high t..done-1"); else n_pass++;
        tick();
        #1;
        n_total++; if (done_o !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done_o); else n_pass++;
        n_total++; if (result_o !== 32'd42) $display("FAIL basic_result_hold: got %h want %h", result_o, 32'd42); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL basic_idle_stall: got %b want 0", stall_o); else n_pass++;
    endtask

    task automatic test_zero();
        int lat; bit ok; logic [31:0] res;
        tick();
        do_mul(32'h0000_1234, 32'd0, lat, ok, res);
        n_total++; if (lat !== exp_lat(32'd0)) $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(32'd0)); else n_pass++;
        n_total++; if (res !== 32'd0) $display("FAIL zero_result: got %h want 0", res); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        int lat; bit ok; logic [31:0] res;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ok, res);
        n_total++; if (res !== 32'h0000_0001) $display("FAIL wrap_all_ones: got %h want 00000001", res); else n_pass++;
        n_total++; if (lat !== exp_lat(32'hFFFF_FFFF)) $display("FAIL wrap_all_ones_latency: got %0d want %0d", lat, exp_lat(32'hFFFF_FFFF)); else n_pass++;
        tick();
        do_mul(32'h8000_0000, 32'd2, lat, ok, res);
        n_total++; if (res !== 32'h0) $display("FAIL wrap_msb: got %h want 0", res); else n_pass++;
        n_total++; if (lat !== exp_lat(32'd2)) $display("FAIL wrap_msb_latency: got %0d want %0d", lat, exp_lat(32'd2)); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; logic [31:0] res;
        do_mul(32'd3, 32'd5, lat, ok, res);
        n_total++; if (res !== 32'd15) $display("FAIL b2b_first_result: got %h want %h", res, 32'd15); else n_pass++;
        n_total++; if (lat !== exp_lat(32'd5)) $display("FAIL b2b_first_latency: got %0d want %0d", lat, exp_lat(32'd5)); else n_pass++;
        // Start raised during the done cycle must be ignored there.
        op_a_i  = 32'h0001_0000;
        op_b_i  = 32'h0001_0000;
        start_i = 1'b1;
        #1;
        n_total++; if (stall_o !== 1'b0) $display("FAIL b2b_start_in_done: stall got %b want 0", stall_o); else n_pass++;
        tick();
        do_mul(32'h0001_0000, 32'h0001_0000, lat, ok, res);
        n_total++; if (!ok) $display("FAIL b2b_second_accept: stall_o shape got bad want high from idle cycle"); else n_pass++;
        n_total++; if (lat !== exp_lat(32'h0001_0000)) $display("FAIL b2b_second_latency: got %0d want %0d", lat, exp_lat(32'h0001_0000)); else n_pass++;
        n_total++; if (res !== 32'h0) $display("FAIL b2b_second_result: got %h want 0", res); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        int lat; bit ok; logic [31:0] res; logic [31:0] held; int dones;
        held = result_o;
        op_a_i  = 32'd5;
        op_b_i  = 32'hFFFF_FFFF;
        start_i = 1'b1;
        #1;
        ok = (stall_o === 1'b1);
        for (int k = 1; k < 10; k++) begin
            tick();
            start_i = 1'b0;
            if (stall_o !== 1'b1) ok = 0;
        end
        n_total++; if (!ok) $display("FAIL flush_busy_stall: stall_o got low want high t..t+9"); else n_pass++;
        tick();
        flush_i = 1'b1;
        #1;
        n_total++; if (stall_o !== 1'b0) $display("FAIL flush_stall_drop: got %b want 0", stall_o); else n_pass++;
        n_total++; if (done_o !== 1'b0) $display("FAIL flush_done: got %b want 0", done_o); else n_pass++;
        tick();
        flush_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o === 1'b1 || stall_o !== 1'b0) dones++;
            tick();
        end
        n_total++; if (dones !== 0) $display("FAIL flush_no_done: got %0d busy/done cycles want 0", dones); else n_pass++;
        n_total++; if (result_o !== held) $display("FAIL flush_result_hold: got %h want %h", result_o, held); else n_pass++;
        do_mul(32'd3, 32'd4, lat, ok, res);
        n_total++; if (res !== 32'd12 || lat !== exp_lat(32'd4)) $display("FAIL flush_restart: got %h/%0d want %h/%0d", res, lat, 32'd12, exp_lat(32'd4)); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int lat; bit ok; logic [31:0] res;
        op_a_i  = 32'd9;
        op_b_i  = 32'd9;
        start_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start_i = 1'b0;
        end
        rst_i = 1'b0;
        #1;
        n_total++; if (stall_o !== 1'b0) $display("FAIL midrst_stall: got %b want 0", stall_o); else n_pass++;
        n_total++; if (done_o !== 1'b0) $display("FAIL midrst_done: got %b want 0", done_o); else n_pass++;
        n_total++; if (result_o !== 32'h0) $display("FAIL midrst_result: got %h want 0", result_o); else n_pass++;
        tick();
        rst_i = 1'b1;
        tick();
        do_mul(32'd11, 32'd13, lat, ok, res);
        n_total++; if (res !== 32'd143) $display("FAIL midrst_next_result: got %h want %h", res, 32'd143); else n_pass++;
        n_total++; if (lat !== exp_lat(32'd13) || !ok) $display("FAIL midrst_next_timing: got %0d want %0d", lat, exp_lat(32'd13)); else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_i   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_a_i  = '0;
        op_b_i  = '0;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
